// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_pkg
// Description : Shared types and helpers for the FIFO drain arbiter. Holds
//               the arbiter state encoding, the round-robin successor
//               function and the burst counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

    // Upper bound on the number of streams the round-robin helper can scan.
    localparam int C_MAX_FLUX   = 32;
    // Width of the optional per-stream pop statistics counters.
    localparam int C_STAT_WIDTH = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Burst counter width: must be able to hold the value BURST itself.
    function automatic int unsigned cnt_width(input int unsigned burst);
        return $clog2(burst + 1);
    endfunction

    // First set bit of mask strictly after 'last', wrapping modulo 'flux'.
    // When nothing is set the function returns 'last'; callers qualify the
    // result with a separate any-eligible test. Scanning from the far end
    // toward last+1 lets the nearest candidate overwrite the result without
    // needing an early exit.
    function automatic int unsigned rr_next(
        input logic [C_MAX_FLUX-1:0] mask,
        input int unsigned           last,
        input int unsigned           flux
    );
        int unsigned idx;
        logic [4:0]  sel;
        rr_next = last;
        for (int i = C_MAX_FLUX; i >= 1; i--) begin
            if (i <= int'(flux)) begin
                idx = last + i;
                if (idx >= flux) begin
                    idx = idx - flux;
                end
                sel = idx[4:0];
                if (mask[sel]) begin
                    rr_next = idx;
                end
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_drain_arbiter_outreg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_outreg
// Description : Output register stage of the drain arbiter. Captures the
//               popped show-ahead word into a valid/ready stream and checks
//               the FIFO tag field against the granted stream.
// Ports       : clk, rst (async, active low)
//               pop, pop_tag, pop_dout  - pop strobe, granted index, FIFO word
//               m_valid/m_ready/m_data/m_tag - downstream stream
//               tag_err (sticky), tag_err_clr (sync clear, set wins)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_outreg
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pop,
    input  logic [TAG_WIDTH-1:0]          pop_tag,
    input  logic [TAG_WIDTH+DATA_WIDTH-1:0] pop_dout,
    input  logic                          m_ready,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [TAG_WIDTH-1:0]          m_tag,
    output logic                          tag_err,
    input  logic                          tag_err_clr
);

    logic w_tag_bad;

    assign w_tag_bad = pop && (pop_dout[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH] != pop_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_tag   <= '0;
            tag_err <= 1'b0;
        end else begin
            // A pop always refills the slot; the arbiter only pops when the
            // slot is empty or being drained this cycle.
            if (pop) begin
                m_valid <= 1'b1;
                m_data  <= pop_dout[DATA_WIDTH-1:0];
                m_tag   <= pop_tag;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            // Tag mismatch is flagged but the word is still forwarded under
            // the granted index. A new error outranks a clear.
            if (w_tag_bad) begin
                tag_err <= 1'b1;
            end else if (tag_err_clr) begin
                tag_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_arbiter
// Description : Read-side consumer of the multi-stream tagged FIFO. Picks a
//               stream by weighted round-robin (hold a stream for up to
//               BURST consecutive reads), issues a one-hot read strobe and
//               registers the show-ahead word into a valid/ready stream.
// Ports       : clk, rst (async, active low)
//               fifo_empty[FLUX], fifo_dout{tag,data}, fifo_read[FLUX]
//               flux_en[FLUX] - per-stream service enable
//               m_valid, m_ready, m_data, m_tag - downstream stream
//               tag_err, tag_err_clr - sticky tag mismatch flag
//               stat_clr, stat_cnt[FLUX] - only with FIFO_DRAIN_STATS_EN
// Options     : `define FIFO_DRAIN_STATS_EN adds saturating per-stream pop
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_arbiter
    import fifo_drain_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FLUX       = 2,
    parameter  int BURST      = 4,
    localparam int TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLUX-1:0]                 fifo_empty,
    input  logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_dout,
    output logic [FLUX-1:0]                 fifo_read,
    input  logic [FLUX-1:0]                 flux_en,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [TAG_WIDTH-1:0]            m_tag,
    output logic                            tag_err,
`ifdef FIFO_DRAIN_STATS_EN
    input  logic                            tag_err_clr,
    input  logic                            stat_clr,
    output logic [C_STAT_WIDTH-1:0]         stat_cnt [FLUX]
`else
    input  logic                            tag_err_clr
`endif
);

    localparam int CW = cnt_width(BURST);

    state_t               r_state, w_state_nxt;
    logic [TAG_WIDTH-1:0] r_cur, w_cur_nxt;
    logic [TAG_WIDTH-1:0] r_last, w_last_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [TAG_WIDTH-1:0] w_pick;
    logic [TAG_WIDTH-1:0] w_pop_idx;
    logic [FLUX-1:0]      w_elig;
    logic                 w_can_take;
    logic                 w_pop;

    assign w_elig     = ~fifo_empty & flux_en;
    assign w_can_take = ~m_valid | m_ready;
    assign w_pick     = TAG_WIDTH'(rr_next(C_MAX_FLUX'(w_elig), 32'(r_last), FLUX));

    // 'last' resets to the highest index so the first scan after reset
    // starts at stream 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_last  <= TAG_WIDTH'(FLUX - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_pop_idx   = r_cur;
        case (r_state)
            IDLE: begin
                if ((|w_elig) && w_can_take) begin
                    w_pop     = 1'b1;
                    w_pop_idx = w_pick;
                    w_cur_nxt = w_pick;
                    w_cnt_nxt = CW'(1);
                    if (BURST == 1) begin
                        w_last_nxt  = w_pick;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                // Losing eligibility ends the burst with no pop this cycle;
                // the next stream is chosen from IDLE on the following cycle.
                if (!w_elig[r_cur]) begin
                    w_last_nxt  = r_cur;
                    w_state_nxt = IDLE;
                end else if (w_can_take) begin
                    w_pop     = 1'b1;
                    w_pop_idx = r_cur;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt + CW'(1) == CW'(BURST)) begin
                        w_last_nxt  = r_cur;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Strobe is gated by reset directly so it drops the instant rst falls.
    always_comb begin
        fifo_read = '0;
        if (w_pop && rst) begin
            fifo_read[w_pop_idx] = 1'b1;
        end
    end

    fifo_drain_outreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_outreg (
        .clk         (clk),
        .rst         (rst),
        .pop         (w_pop),
        .pop_tag     (w_pop_idx),
        .pop_dout    (fifo_dout),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_tag       (m_tag),
        .tag_err     (tag_err),
        .tag_err_clr (tag_err_clr)
    );

`ifdef FIFO_DRAIN_STATS_EN
    generate
        for (genvar g = 0; g < FLUX; g++) begin : g_stat
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stat_cnt[g] <= '0;
                end else if (stat_clr) begin
                    // A pop coinciding with the clear is counted.
                    stat_cnt[g] <= fifo_read[g] ? C_STAT_WIDTH'(1) : '0;
                end else if (fifo_read[g] && (stat_cnt[g] != '1)) begin
                    stat_cnt[g] <= stat_cnt[g] + C_STAT_WIDTH'(1);
                end
            end
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain_arbiter
// Description : Self-checking bench for fifo_drain_arbiter (default build).
//               Emulates a multi-stream show-ahead FIFO and compares the
//               output stream against a burst round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_arbiter;

    localparam int DW    = 8;
    localparam int FX    = 2;
    localparam int BU    = 4;
    localparam int TW    = 1;
    localparam int DEPTH = 64;
    localparam int LOGN  = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [FX-1:0] fifo_empty;
    logic [FX-1:0] fifo_read;
    logic [FX-1:0] flux_en;
    logic [TW+DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tag;
    logic          tag_err;
    logic          tag_err_clr;

    int total = 0;
    int bad   = 0;

    // FIFO emulation: fixed contents per stream, pointer advanced on read.
    logic [DW-1:0] mem [FX][DEPTH];
    int            fill [FX];
    int            rd_ptr [FX];
    logic          fifo_clr;
    logic          force_tag;
    logic [TW-1:0] force_val;
    int            sel;

    // Observation log written only by the monitor.
    logic [TW+DW-1:0] obs [LOGN];
    int               obs_cnt;
    logic [FX-1:0]    rd_trace [LOGN];
    logic             vld_trace [LOGN];
    int               ncyc;
    int               viol;
    logic             prev_hold;
    logic [TW+DW-1:0] prev_word;

    logic [TW+DW-1:0] exp_q [LOGN];
    int               exp_len;

    always #5 clk = ~clk;

    fifo_drain_arbiter #(
        .DATA_WIDTH (DW),
        .FLUX       (FX),
        .BURST      (BU)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_read   (fifo_read),
        .flux_en     (flux_en),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_tag       (m_tag),
        .tag_err     (tag_err),
        .tag_err_clr (tag_err_clr)
    );

    always_comb begin
        fifo_empty = '0;
        for (int f = 0; f < FX; f++) fifo_empty[f] = (rd_ptr[f] >= fill[f]);
    end

    assign sel       = fifo_read[1] ? 1 : 0;
    assign fifo_dout = {force_tag ? force_val : TW'(sel), mem[sel][rd_ptr[sel] % DEPTH]};

    always @(posedge clk) begin
        for (int f = 0; f < FX; f++) begin
            if (fifo_clr)          rd_ptr[f] <= 0;
            else if (fifo_read[f]) rd_ptr[f] <= rd_ptr[f] + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_clr) begin
            obs_cnt   <= 0;
            ncyc      <= 0;
            viol      <= 0;
            prev_hold <= 1'b0;
        end else begin
            if (ncyc < LOGN) begin
                rd_trace[ncyc]  <= fifo_read;
                vld_trace[ncyc] <= m_valid;
                ncyc            <= ncyc + 1;
            end
            if (m_valid && m_ready && obs_cnt < LOGN) begin
                obs[obs_cnt] <= {m_tag, m_data};
                obs_cnt      <= obs_cnt + 1;
            end
            viol <= viol
                  + ((($countones(fifo_read) > 1) || ((fifo_read & ~(~fifo_empty & flux_en)) != '0)) ? 1 : 0)
                  + ((prev_hold && m_valid && ({m_tag, m_data} != prev_word)) ? 1 : 0);
            prev_hold <= rst && m_valid && !m_ready;
            prev_word <= {m_tag, m_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, load new FIFO contents, release.
    task automatic start(input int n0, input int n1, input logic [FX-1:0] en, input logic rdy);
        rst         = 1'b0;
        fifo_clr    = 1'b1;
        m_ready     = rdy;
        tag_err_clr = 1'b0;
        force_tag   = 1'b0;
        force_val   = '0;
        flux_en     = en;
        fill[0]     = n0;
        fill[1]     = n1;
        for (int f = 0; f < FX; f++)
            for (int i = 0; i < DEPTH; i++) mem[f][i] = 8'($urandom);
        tick();
        tick();
        rst      = 1'b1;
        fifo_clr = 1'b0;
    endtask

    task automatic run_until(input int n, input bit rnd);
        for (int c = 0; c < 2000 && obs_cnt < n; c++) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        m_ready = 1'b1;
        repeat (8) tick();
    endtask

    // Reference: serve streams in round-robin order starting at stream 0,
    // each visit taking up to BU words or until the stream is exhausted.
    task automatic build_expected();
        int rem [FX];
        int taken [FX];
        int last;
        int pick;
        int k;
        for (int f = 0; f < FX; f++) begin
            rem[f]   = fill[f];
            taken[f] = 0;
        end
        last    = FX - 1;
        exp_len = 0;
        for (int guard = 0; guard < LOGN; guard++) begin
            pick = -1;
            for (int i = 1; i <= FX; i++) begin
                int f;
                f = (last + i) % FX;
                if (pick < 0 && rem[f] > 0 && flux_en[f]) pick = f;
            end
            if (pick < 0) break;
            k = (rem[pick] < BU) ? rem[pick] : BU;
            for (int j = 0; j < k; j++) begin
                exp_q[exp_len] = {TW'(pick), mem[pick][taken[pick]]};
                exp_len++;
                taken[pick]++;
            end
            rem[pick] -= k;
            last = pick;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; fifo_clr = 1'b1; m_ready = 1'b1; tag_err_clr = 1'b0;
        force_tag = 1'b0; force_val = '0; flux_en = 2'b11;
        fill[0] = 2; fill[1] = 2;
        tick();
        tick();
        total++; if (fifo_read !== 2'b00) begin bad++; $display("FAIL reset_read got=%b exp=00", fifo_read); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err got=%b exp=0", tag_err); end
        total++; if ({m_tag, m_data} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", {m_tag, m_data}); end
        rst = 1'b1; fifo_clr = 1'b0;
        #1;
        total++; if (fifo_read !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b exp=01", fifo_read); end
    endtask

    task automatic test_burst_order();
        logic [8:0] order;
        order = 9'b001110000;  // bit i = tag of i-th word
        start(6, 3, 2'b11, 1'b1);
        build_expected();
        run_until(exp_len, 1'b0);
        total++; if (obs_cnt !== 9) begin bad++; $display("FAIL burst_count got=%0d exp=9", obs_cnt); end
        for (int i = 0; i < 9 && i < obs_cnt; i++) begin
            total++;
            if (obs[i][DW] !== order[i] || obs[i] !== exp_q[i]) begin
                bad++; $display("FAIL burst_word[%0d] got=%h exp=%h", i, obs[i], exp_q[i]);
            end
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL burst_legal got=%0d exp=0", viol); end
    endtask

    task automatic test_stall();
        start(4, 0, 2'b11, 1'b0);
        repeat (6) tick();
        total++; if (rd_ptr[0] !== 1) begin bad++; $display("FAIL stall_pops got=%0d exp=1", rd_ptr[0]); end
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", m_valid); end
        total++; if (m_data !== mem[0][0]) begin bad++; $display("FAIL stall_data got=%h exp=%h", m_data, mem[0][0]); end
        total++; if (fifo_read !== 2'b00) begin bad++; $display("FAIL stall_read got=%b exp=00", fifo_read); end
        build_expected();
        run_until(exp_len, 1'b0);
        total++; if (obs_cnt !== exp_len) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", obs_cnt, exp_len); end
        for (int i = 0; i < exp_len && i < obs_cnt; i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL stall_word[%0d] got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL stall_stable got=%0d exp=0", viol); end
    endtask

    task automatic test_flux_en();
        start(3, 3, 2'b01, 1'b1);
        build_expected();
        run_until(exp_len, 1'b0);
        total++; if (obs_cnt !== 3) begin bad++; $display("FAIL en_count got=%0d exp=3", obs_cnt); end
        total++; if (rd_ptr[1] !== 0) begin bad++; $display("FAIL en_masked_pops got=%0d exp=0", rd_ptr[1]); end
        for (int i = 0; i < exp_len && i < obs_cnt; i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL en_word[%0d] got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL en_legal got=%0d exp=0", viol); end
    endtask

    task automatic test_tag_err();
        start(3, 0, 2'b11, 1'b1);
        force_tag   = 1'b1;
        force_val   = 1'b1;
        tag_err_clr = 1'b1;
        for (int c = 0; c < 20 && !m_valid; c++) tick();
        total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL tag_err_set_wins got=%b exp=1", tag_err); end
        total++; if (m_data !== mem[0][0] || m_tag !== 1'b0) begin
            bad++; $display("FAIL tag_err_forward got=%h exp=%h", {m_tag, m_data}, {1'b0, mem[0][0]});
        end
        force_tag   = 1'b0;
        tag_err_clr = 1'b0;
        tick();
        total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL tag_err_sticky got=%b exp=1", tag_err); end
        tag_err_clr = 1'b1;
        tick();
        tag_err_clr = 1'b0;
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL tag_err_clear got=%b exp=0", tag_err); end
        build_expected();
        run_until(exp_len, 1'b0);
        total++; if (obs_cnt !== exp_len) begin bad++; $display("FAIL tag_count got=%0d exp=%0d", obs_cnt, exp_len); end
        for (int i = 0; i < exp_len && i < obs_cnt; i++) begin
            total++;
            if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL tag_word[%0d] got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_bubble();
        logic [1:0] rd_exp [6];
        logic       vl_exp [6];
        rd_exp = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
        vl_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        start(2, 3, 2'b11, 1'b1);
        repeat (8) tick();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rd_trace[i] !== rd_exp[i] || vld_trace[i] !== vl_exp[i]) begin
                bad++;
                $display("FAIL bubble_cycle[%0d] got read=%b valid=%b exp read=%b valid=%b",
                         i, rd_trace[i], vld_trace[i], rd_exp[i], vl_exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        start(8, 8, 2'b11, 1'b1);
        repeat (5) tick();
        total++; if (fifo_read !== 2'b10) begin bad++; $display("FAIL midrst_pre_read got=%b exp=10", fifo_read); end
        rst = 1'b0;
        #1;
        total++; if (fifo_read !== 2'b00) begin bad++; $display("FAIL midrst_read got=%b exp=00", fifo_read); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", m_valid); end
        tick();
        total++; if (rd_ptr[0] !== 4 || rd_ptr[1] !== 1) begin
            bad++; $display("FAIL midrst_fifo_kept got=%0d/%0d exp=4/1", rd_ptr[0], rd_ptr[1]);
        end
        rst = 1'b1;
        #1;
        total++; if (fifo_read !== 2'b01) begin bad++; $display("FAIL midrst_restart got=%b exp=01", fifo_read); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            start($urandom_range(0, 20), $urandom_range(0, 20), 2'($urandom_range(0, 3)), 1'b1);
            build_expected();
            run_until(exp_len, 1'b1);
            total++; if (obs_cnt !== exp_len) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, obs_cnt, exp_len); end
            for (int i = 0; i < exp_len && i < obs_cnt; i++) begin
                total++;
                if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_word[%0d] got=%h exp=%h", it, i, obs[i], exp_q[i]); end
            end
            total++; if (viol !== 0) begin bad++; $display("FAIL rnd%0d_protocol got=%0d exp=0", it, viol); end
        end
    endtask

    initial begin
        test_reset();
        test_burst_order();
        test_stall();
        test_flux_en();
        test_tag_err();
        test_bubble();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
